ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// EX pipeline stage: ALU execution, 32-cycle restoring divider, and data SRAM request
// generation (byte/halfword write strobes and store-data replication).

// Combinational ALU, one-hot operation select:
// [0] add [1] sub [2] slt [3] sltu [4] and [5] nor [6] or [7] xor [8] sll [9] srl [10] sra [11] lui
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    logic        w_sub_like;
    logic [31:0] w_adder_b;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_slt;
    logic        w_sltu;
    logic [31:0] w_sra;

    assign w_sub_like       = alu_op[1] | alu_op[2] | alu_op[3];
    assign w_adder_b        = w_sub_like ? ~alu_src2 : alu_src2;
    assign {w_cout, w_sum}  = {1'b0, alu_src1} + {1'b0, w_adder_b} + {32'd0, w_sub_like};
    assign w_slt            = (alu_src1[31] & ~alu_src2[31]) |
                              (~(alu_src1[31] ^ alu_src2[31]) & w_sum[31]);
    assign w_sltu           = ~w_cout;
    assign w_sra            = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);

    assign alu_result = ({32{alu_op[0] | alu_op[1]}} & w_sum)
                      | ({32{alu_op[2]}}  & {31'd0, w_slt})
                      | ({32{alu_op[3]}}  & {31'd0, w_sltu})
                      | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                      | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                      | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                      | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                      | ({32{alu_op[8]}}  & (alu_src1 << alu_src2[4:0]))
                      | ({32{alu_op[9]}}  & (alu_src1 >> alu_src2[4:0]))
                      | ({32{alu_op[10]}} & w_sra)
                      | ({32{alu_op[11]}} & alu_src2);
endmodule

module ex_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         id_to_ex_valid,
    input  logic [201:0] id_to_ex_bus,
    output logic         ex_allowin,
    input  logic         mem_allowin,
    output logic         ex_to_mem_valid,
    output logic [155:0] ex_to_mem_bus,
    output logic [38:0]  ex_to_id_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    logic         r_ex_valid;
    logic [201:0] r_bus;
    div_state_t   r_state;
    logic [4:0]   r_cnt;
    logic [31:0]  r_rem;
    logic [31:0]  r_quo;

    logic [31:0]  w_pc, w_src1, w_src2, w_rkd_value, w_csr_wmask;
    logic [11:0]  w_alu_op;
    logic         w_div_en, w_div_mod, w_div_signed, w_res_from_mem, w_mem_we, w_rf_we;
    logic [4:0]   w_rf_waddr;
    logic         w_op_b, w_op_h, w_op_u, w_csr_re, w_csr_we;
    logic [13:0]  w_csr_num;

    logic         w_ready_go;
    logic         w_transfer;
    logic [31:0]  w_alu_result;
    logic [31:0]  w_result;

    logic         w_src1_neg, w_src2_neg, w_quo_neg;
    logic [31:0]  w_mag1, w_mag2;
    logic [31:0]  w_step_rem, w_step_quo;
    logic [32:0]  w_trial;
    logic         w_borrow;
    logic [31:0]  w_next_rem, w_next_quo;
    logic [31:0]  w_quo_fix, w_rem_fix;
    logic [3:0]   w_we_raw;

    assign {w_pc, w_alu_op, w_src1, w_src2, w_div_en, w_div_mod, w_div_signed,
            w_res_from_mem, w_mem_we, w_rf_we, w_rf_waddr, w_rkd_value,
            w_op_b, w_op_h, w_op_u, w_csr_re, w_csr_we, w_csr_num, w_csr_wmask} = r_bus;

    assign w_ready_go      = ~w_div_en | (r_state == DIV_DONE);
    assign ex_allowin      = ~r_ex_valid | (w_ready_go & mem_allowin);
    assign ex_to_mem_valid = r_ex_valid & w_ready_go;
    assign w_transfer      = r_ex_valid & w_ready_go & mem_allowin;

    // Valid bit advances only when EX can accept, so a stalled instruction is held.
    always_ff @(posedge clk) begin
        if (!resetn)
            r_ex_valid <= 1'b0;
        else if (ex_allowin)
            r_ex_valid <= id_to_ex_valid;
    end

    // Capture the decoded instruction on a handshake.
    always_ff @(posedge clk) begin
        if (!resetn)
            r_bus <= '0;
        else if (id_to_ex_valid & ex_allowin)
            r_bus <= id_to_ex_bus;
    end

    alu u_alu (
        .alu_op     (w_alu_op),
        .alu_src1   (w_src1),
        .alu_src2   (w_src2),
        .alu_result (w_alu_result)
    );

    // Restoring division on magnitudes; the first iteration is taken on the IDLE->BUSY
    // edge straight from the operands, so DONE is reached in the 33rd cycle in EX.
    assign w_src1_neg = w_div_signed & w_src1[31];
    assign w_src2_neg = w_div_signed & w_src2[31];
    assign w_quo_neg  = w_div_signed & (w_src1[31] ^ w_src2[31]);
    assign w_mag1     = w_src1_neg ? (~w_src1 + 32'd1) : w_src1;
    assign w_mag2     = w_src2_neg ? (~w_src2 + 32'd1) : w_src2;
    assign w_step_rem = (r_state == DIV_IDLE) ? '0 : r_rem;
    assign w_step_quo = (r_state == DIV_IDLE) ? w_mag1 : r_quo;
    assign w_trial    = {w_step_rem, w_step_quo[31]} - {1'b0, w_mag2};
    assign w_borrow   = w_trial[32];
    assign w_next_rem = w_borrow ? {w_step_rem[30:0], w_step_quo[31]} : w_trial[31:0];
    assign w_next_quo = {w_step_quo[30:0], ~w_borrow};
    assign w_quo_fix  = w_quo_neg  ? (~r_quo + 32'd1) : r_quo;
    assign w_rem_fix  = w_src1_neg ? (~r_rem + 32'd1) : r_rem;

    // Divider sequencer: IDLE -> BUSY (32 iterations) -> DONE -> IDLE on transfer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (r_ex_valid & w_div_en) begin
                        r_rem   <= w_next_rem;
                        r_quo   <= w_next_quo;
                        r_cnt   <= 5'd1;
                        r_state <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    r_rem <= w_next_rem;
                    r_quo <= w_next_quo;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31)
                        r_state <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (w_transfer)
                        r_state <= DIV_IDLE;
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

    assign w_result = w_div_en ? (w_div_mod ? w_rem_fix : w_quo_fix) : w_alu_result;

    // Byte-lane strobes by access size and low address bits.
    always_comb begin
        w_we_raw = 4'b1111;
        if (w_op_b)
            w_we_raw = 4'b0001 << w_result[1:0];
        else if (w_op_h)
            w_we_raw = w_result[1] ? 4'b1100 : 4'b0011;
    end

    assign data_sram_en    = w_transfer & (w_res_from_mem | w_mem_we);
    assign data_sram_we    = (data_sram_en & w_mem_we) ? w_we_raw : 4'b0000;
    assign data_sram_addr  = w_result;
    assign data_sram_wdata = w_op_b ? {4{w_rkd_value[7:0]}} :
                             w_op_h ? {2{w_rkd_value[15:0]}} : w_rkd_value;

    assign ex_to_mem_bus = {w_pc, w_res_from_mem, w_rf_we, w_rf_waddr, w_result, w_rkd_value,
                            w_result[1:0], w_op_b, w_op_h, w_op_u, w_csr_re, w_csr_we,
                            w_csr_num, w_csr_wmask};
    assign ex_to_id_bus  = {r_ex_valid & w_rf_we, w_rf_waddr, r_ex_valid & w_res_from_mem, w_result};
endmodule
